// File: rtl/decoder_round_controller.sv
// Round sequencer between a syndrome source, the Helios decoder and a result sink.
// A one-entry frame buffer feeds an IDLE/START/WAIT/REPORT controller that has a result timeout.
module decoder_round_controller #(
   parameter int unsigned PU_COUNT                = 18,
   parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
   parameter int unsigned ROUND_ID_WIDTH          = 16,
   parameter int unsigned TIMEOUT_CYCLES          = 1024,
   parameter int unsigned STAT_WIDTH              = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [PU_COUNT-1:0]                in_measurements,
   input  logic [ROUND_ID_WIDTH-1:0]          in_round_id,
   output logic                               dec_new_round_start,
   output logic [PU_COUNT-1:0]                dec_measurements,
   input  logic                               dec_result_valid,
   input  logic [ITERATION_COUNTER_WIDTH-1:0] dec_iteration_counter,
   input  logic [31:0]                        dec_cycle_counter,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [ROUND_ID_WIDTH-1:0]          out_round_id,
   output logic [ITERATION_COUNTER_WIDTH-1:0] out_iterations,
   output logic [31:0]                        out_cycles,
   output logic                               out_timeout,
   output logic                               busy,
   output logic [STAT_WIDTH-1:0]              rounds_done,
   output logic [STAT_WIDTH-1:0]              timeouts
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_REPORT} state_t;

   state_t                             state_q, state_d;
   logic                               pend_full_q, pend_full_d;
   logic [PU_COUNT-1:0]                pend_meas_q, pend_meas_d;
   logic [ROUND_ID_WIDTH-1:0]          pend_id_q, pend_id_d;
   logic [PU_COUNT-1:0]                act_meas_q, act_meas_d;
   logic [ROUND_ID_WIDTH-1:0]          act_id_q, act_id_d;
   logic                               start_q, start_d;
   logic [TW-1:0]                      timer_q, timer_d;
   logic                               armed_q, armed_d;
   logic                               out_valid_q, out_valid_d;
   logic [ROUND_ID_WIDTH-1:0]          out_id_q, out_id_d;
   logic [ITERATION_COUNTER_WIDTH-1:0] out_iter_q, out_iter_d;
   logic [31:0]                        out_cycles_q, out_cycles_d;
   logic                               out_timeout_q, out_timeout_d;
   logic [STAT_WIDTH-1:0]              rounds_q, rounds_d;
   logic [STAT_WIDTH-1:0]              tmo_q, tmo_d;

   always_comb begin
      state_d       = state_q;
      pend_full_d   = pend_full_q;
      pend_meas_d   = pend_meas_q;
      pend_id_d     = pend_id_q;
      act_meas_d    = act_meas_q;
      act_id_d      = act_id_q;
      start_d       = 1'b0;
      timer_d       = timer_q;
      armed_d       = armed_q;
      out_valid_d   = out_valid_q;
      out_id_d      = out_id_q;
      out_iter_d    = out_iter_q;
      out_cycles_d  = out_cycles_q;
      out_timeout_d = out_timeout_q;
      rounds_d      = rounds_q;
      tmo_d         = tmo_q;

      // Accept only into an empty buffer and pop only a full one, so the two never coincide.
      if (in_valid && !pend_full_q) begin
         pend_full_d = 1'b1;
         pend_meas_d = in_measurements;
         pend_id_d   = in_round_id;
      end

      case (state_q)
         S_IDLE: begin
            if (pend_full_q) begin
               act_meas_d  = pend_meas_q;
               act_id_d    = pend_id_q;
               pend_full_d = 1'b0;
               start_d     = 1'b1;
               state_d     = S_START;
            end
         end
         S_START: begin
            timer_d = '0;
            armed_d = 1'b0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (!dec_result_valid) armed_d = 1'b1;
            // A result level left over from the previous round is ignored until it has been seen low.
            if (armed_q && dec_result_valid) begin
               out_valid_d   = 1'b1;
               out_id_d      = act_id_q;
               out_iter_d    = dec_iteration_counter;
               out_cycles_d  = dec_cycle_counter;
               out_timeout_d = 1'b0;
               state_d       = S_REPORT;
            end else if (timer_q == TIMER_LAST) begin
               out_valid_d   = 1'b1;
               out_id_d      = act_id_q;
               out_iter_d    = '0;
               out_cycles_d  = 32'(TIMEOUT_CYCLES);
               out_timeout_d = 1'b1;
               tmo_d         = tmo_q + 1'b1;
               state_d       = S_REPORT;
            end
         end
         S_REPORT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               rounds_d    = rounds_q + 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         pend_full_q   <= 1'b0;
         pend_meas_q   <= '0;
         pend_id_q     <= '0;
         act_meas_q    <= '0;
         act_id_q      <= '0;
         start_q       <= 1'b0;
         timer_q       <= '0;
         armed_q       <= 1'b0;
         out_valid_q   <= 1'b0;
         out_id_q      <= '0;
         out_iter_q    <= '0;
         out_cycles_q  <= '0;
         out_timeout_q <= 1'b0;
         rounds_q      <= '0;
         tmo_q         <= '0;
      end else begin
         state_q       <= state_d;
         pend_full_q   <= pend_full_d;
         pend_meas_q   <= pend_meas_d;
         pend_id_q     <= pend_id_d;
         act_meas_q    <= act_meas_d;
         act_id_q      <= act_id_d;
         start_q       <= start_d;
         timer_q       <= timer_d;
         armed_q       <= armed_d;
         out_valid_q   <= out_valid_d;
         out_id_q      <= out_id_d;
         out_iter_q    <= out_iter_d;
         out_cycles_q  <= out_cycles_d;
         out_timeout_q <= out_timeout_d;
         rounds_q      <= rounds_d;
         tmo_q         <= tmo_d;
      end
   end

   assign in_ready            = ~pend_full_q;
   assign dec_new_round_start = start_q;
   assign dec_measurements    = act_meas_q;
   assign out_valid           = out_valid_q;
   assign out_round_id        = out_id_q;
   assign out_iterations      = out_iter_q;
   assign out_cycles          = out_cycles_q;
   assign out_timeout         = out_timeout_q;
   assign busy                = (state_q != S_IDLE) || pend_full_q;
   assign rounds_done         = rounds_q;
   assign timeouts            = tmo_q;

endmodule

// File: tb/tb_decoder_round_controller.sv
// Bench for decoder_round_controller: table vectors, directed corner sequences and
// random rounds against a transaction-level scoreboard with a scripted decoder responder.
module tb_decoder_round_controller;

   localparam int unsigned PU = 18;
   localparam int unsigned IW = 8;
   localparam int unsigned RW = 16;
   localparam int unsigned TO = 16;
   localparam int unsigned SW = 32;

   logic          clk;
   logic          reset;
   logic          in_valid, in_ready;
   logic [PU-1:0] in_measurements;
   logic [RW-1:0] in_round_id;
   logic          dec_new_round_start;
   logic [PU-1:0] dec_measurements;
   logic          dec_result_valid;
   logic [IW-1:0] dec_iteration_counter;
   logic [31:0]   dec_cycle_counter;
   logic          out_valid, out_ready;
   logic [RW-1:0] out_round_id;
   logic [IW-1:0] out_iterations;
   logic [31:0]   out_cycles;
   logic          out_timeout, busy;
   logic [SW-1:0] rounds_done, timeouts;

   decoder_round_controller #(
      .PU_COUNT(PU), .ITERATION_COUNTER_WIDTH(IW), .ROUND_ID_WIDTH(RW),
      .TIMEOUT_CYCLES(TO), .STAT_WIDTH(SW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_measurements(in_measurements), .in_round_id(in_round_id),
      .dec_new_round_start(dec_new_round_start), .dec_measurements(dec_measurements),
      .dec_result_valid(dec_result_valid), .dec_iteration_counter(dec_iteration_counter),
      .dec_cycle_counter(dec_cycle_counter),
      .out_valid(out_valid), .out_ready(out_ready), .out_round_id(out_round_id),
      .out_iterations(out_iterations), .out_cycles(out_cycles), .out_timeout(out_timeout),
      .busy(busy), .rounds_done(rounds_done), .timeouts(timeouts)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] id;
      logic [PU-1:0] meas;
   } frame_t;

   // Decoder behaviour for one round plus the record the controller must produce.
   typedef struct {
      int unsigned   k;       // cycles a stale result level is kept high after the start
      int unsigned   d;       // low cycles before the fresh result rises
      bit            silent;  // never answer
      logic [IW-1:0] iter;
      logic [31:0]   cyc;
      logic [IW-1:0] e_iter;
      logic [31:0]   e_cyc;
      bit            e_to;
      int unsigned   e_lat;   // cycles from start pulse to out_valid
   } plan_t;

   typedef struct {
      frame_t f;
      plan_t  p;
   } vec_t;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned starts = 0;
   int unsigned cyc_n = 0;
   int unsigned start_t = 0;
   bit          lat_pend = 0;
   bit          prev_stall = 0;
   bit          prev_start = 0;
   bit          took = 0;
   bit          rand_sink = 0;
   logic [RW+IW+32:0] saved_out;
   logic [31:0] model_rounds = '0;
   logic [31:0] model_to = '0;
   frame_t      src_q[$];
   frame_t      frames[$];
   frame_t      act_q[$];
   plan_t       plan_q[$];
   plan_t       res_q[$];
   frame_t      mon_f;
   plan_t       mon_p;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name, input string why);
      checks++;
      errors++;
      $display("FAIL %s %s", name, why);
   endtask

   // Spec-level outcome: the round offers TO result samples; the fresh rise lands on sample k+d.
   function automatic plan_t mk_plan(input int unsigned k, input int unsigned d, input bit silent,
                                     input logic [IW-1:0] iter, input logic [31:0] cyc);
      plan_t p;
      p.k = k; p.d = d; p.silent = silent; p.iter = iter; p.cyc = cyc;
      p.e_to   = silent || (k + d >= TO);
      p.e_iter = p.e_to ? '0 : iter;
      p.e_cyc  = p.e_to ? TO : cyc;
      p.e_lat  = p.e_to ? TO + 1 : k + d + 2;
      return p;
   endfunction

   function automatic plan_t rand_plan();
      int unsigned k, d;
      k = $urandom_range(0, 2);
      d = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 17 - k);
      return mk_plan(k, d, $urandom_range(0, 7) == 0, IW'($urandom), $urandom);
   endfunction

   function automatic vec_t mkv(input logic [RW-1:0] id, input logic [PU-1:0] meas,
                                input int unsigned k, input int unsigned d, input bit silent,
                                input logic [IW-1:0] iter, input logic [31:0] cyc,
                                input logic [IW-1:0] e_iter, input logic [31:0] e_cyc,
                                input bit e_to, input int unsigned e_lat);
      vec_t v;
      v.f.id = id; v.f.meas = meas;
      v.p.k = k; v.p.d = d; v.p.silent = silent; v.p.iter = iter; v.p.cyc = cyc;
      v.p.e_iter = e_iter; v.p.e_cyc = e_cyc; v.p.e_to = e_to; v.p.e_lat = e_lat;
      return v;
   endfunction

   // Frame source: holds in_valid until the monitor has seen the transfer.
   always begin
      @(posedge clk); #1;
      if (in_valid && took) begin
         src_q.delete(0);
         in_valid = 0;
      end
      took = 0;
      if (!in_valid && src_q.size() != 0) begin
         in_valid        = 1;
         in_round_id     = src_q[0].id;
         in_measurements = src_q[0].meas;
      end
   end

   always begin
      @(posedge clk); #1;
      if (rand_sink) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Decoder responder, driven by a plan per start pulse.
   always begin
      @(negedge clk);
      if (reset && dec_new_round_start) begin
         plan_t p;
         if (plan_q.size() != 0) p = plan_q.pop_front();
         else p = rand_plan();
         res_q.push_back(p);
         @(posedge clk); #1;
         repeat (p.k) begin @(posedge clk); #1; end
         dec_result_valid = 0;
         if (!p.silent) begin
            repeat (p.d) begin @(posedge clk); #1; end
            dec_iteration_counter = p.iter;
            dec_cycle_counter     = p.cyc;
            dec_result_valid      = 1;
         end
      end
   end

   // Scoreboard monitor, sampling between clock edges.
   always @(negedge clk) begin
      cyc_n++;
      if (reset) begin
         if (in_valid && in_ready) begin
            frames.push_back('{id: in_round_id, meas: in_measurements});
            took = 1;
         end
         if (dec_new_round_start) begin
            starts++;
            chk("start_width", 64'(prev_start), 64'(0));
            if (frames.size() == 0) fail("start_frame", "start pulse without an accepted frame");
            else begin
               mon_f = frames.pop_front();
               chk("dec_meas", 64'(dec_measurements), 64'(mon_f.meas));
               act_q.push_back(mon_f);
            end
            start_t  = cyc_n;
            lat_pend = 1;
         end
         if (out_valid && lat_pend) begin
            lat_pend = 0;
            if (res_q.size() == 0) fail("latency", "record without a decoder round");
            else chk("latency", 64'(cyc_n - start_t), 64'(res_q[0].e_lat));
         end
         if (out_valid && prev_stall)
            chk("out_stable", 64'({out_round_id, out_iterations, out_cycles, out_timeout}), 64'(saved_out));
         if (out_valid && out_ready) begin
            if (act_q.size() == 0 || res_q.size() == 0) fail("record", "unexpected record handed to sink");
            else begin
               mon_f = act_q.pop_front();
               mon_p = res_q.pop_front();
               chk("rec_id", 64'(out_round_id), 64'(mon_f.id));
               chk("rec_iter", 64'(out_iterations), 64'(mon_p.e_iter));
               chk("rec_cycles", 64'(out_cycles), 64'(mon_p.e_cyc));
               chk("rec_timeout", 64'(out_timeout), 64'(mon_p.e_to));
               model_to = model_to + 32'(mon_p.e_to);
               chk("timeouts", 64'(timeouts), 64'(model_to));
               chk("rounds_done", 64'(rounds_done), 64'(model_rounds));
               model_rounds = model_rounds + 1;
            end
         end
         prev_stall = out_valid && !out_ready;
         saved_out  = {out_round_id, out_iterations, out_cycles, out_timeout};
         prev_start = dec_new_round_start;
      end
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      chk({tag, "_start"}, 64'(dec_new_round_start), 64'(0));
      chk({tag, "_dec_meas"}, 64'(dec_measurements), 64'(0));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_out_rec"}, 64'({out_round_id, out_iterations, out_cycles, out_timeout}), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_counters"}, 64'({rounds_done, timeouts}), 64'(0));
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk); #2;
      reset = 0;
      in_valid = 0;
      took = 0;
      src_q.delete(); plan_q.delete(); frames.delete(); act_q.delete(); res_q.delete();
      lat_pend = 0; prev_stall = 0; prev_start = 0;
      model_rounds = '0; model_to = '0;
      #1;
      chk_reset_state(tag);
      repeat (3) @(negedge clk);
      #2 reset = 1;
   endtask

   task automatic wait_idle(input string tag, input int unsigned budget);
      int unsigned n = 0;
      bit done = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (src_q.size() == 0) && !in_valid && !busy && (res_q.size() == 0);
      end
      if (!done) fail({tag, "_idle"}, "controller did not drain within the cycle budget");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[7];
      int unsigned s0;
      logic [31:0] r0, t0;
      int unsigned n;

      clk = 0; reset = 0; in_valid = 0; in_measurements = '0; in_round_id = '0;
      dec_result_valid = 0; dec_iteration_counter = '0; dec_cycle_counter = '0; out_ready = 1;

      tbl[0] = mkv(16'h0005, 18'h00011, 0, 10, 0, 8'd3,   32'd40,       8'd3,   32'd40,       0, 12);
      tbl[1] = mkv(16'h0006, 18'h2AAAA, 1, 1,  0, 8'd2,   32'd77,       8'd2,   32'd77,       0, 4);
      tbl[2] = mkv(16'h0007, 18'h15555, 0, 0,  1, 8'd9,   32'd99,       8'd0,   32'd16,       1, 17);
      tbl[3] = mkv(16'hFFFF, 18'h3FFFF, 2, 3,  0, 8'hFF,  32'hFFFFFFFF, 8'hFF,  32'hFFFFFFFF, 0, 7);
      tbl[4] = mkv(16'h0008, 18'h00001, 0, 15, 0, 8'd4,   32'd123,      8'd4,   32'd123,      0, 17);
      tbl[5] = mkv(16'h0009, 18'h20000, 0, 16, 0, 8'd5,   32'd200,      8'd0,   32'd16,       1, 17);
      tbl[6] = mkv(16'h0000, 18'h00000, 0, 1,  0, 8'd1,   32'd1,        8'd1,   32'd1,        0, 3);

      do_reset("init");

      for (int i = 0; i < 7; i++) begin
         s0 = starts; r0 = rounds_done; t0 = timeouts;
         plan_q.push_back(tbl[i].p);
         src_q.push_back(tbl[i].f);
         wait_idle($sformatf("tbl%0d", i), 200);
         chk($sformatf("tbl%0d_starts", i), 64'(starts - s0), 64'(1));
         chk($sformatf("tbl%0d_dec_meas", i), 64'(dec_measurements), 64'(tbl[i].f.meas));
         chk($sformatf("tbl%0d_rounds", i), 64'(rounds_done), 64'(r0 + 1));
         chk($sformatf("tbl%0d_timeouts", i), 64'(timeouts), 64'(t0 + 32'(tbl[i].p.e_to)));
      end

      // Buffering: id1 held in REPORT, id2 pending, id3 stalled at the source.
      @(posedge clk); #1 out_ready = 0;
      for (int i = 1; i <= 3; i++) begin
         plan_q.push_back(mk_plan(0, 3, 0, IW'(i), 32'(i * 10)));
         src_q.push_back('{id: RW'(i), meas: PU'(i * 7)});
      end
      repeat (20) @(negedge clk);
      chk("buf_out_valid", 64'(out_valid), 64'(1));
      chk("buf_out_id", 64'(out_round_id), 64'(1));
      chk("buf_in_ready", 64'(in_ready), 64'(0));
      chk("buf_src_stall", 64'({in_valid, in_round_id}), 64'({1'b1, 16'd3}));
      r0 = rounds_done;
      @(posedge clk); #1 out_ready = 1;
      wait_idle("buf", 300);
      chk("buf_rounds", 64'(rounds_done), 64'(r0 + 3));

      // Sink stall for 20 cycles in REPORT.
      @(posedge clk); #1 out_ready = 0;
      plan_q.push_back(mk_plan(0, 2, 0, 8'd6, 32'd66));
      src_q.push_back('{id: 16'h0A0A, meas: 18'h0F0F0});
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (!out_valid) fail("stall_wait", "no record within the cycle budget");
      r0 = rounds_done;
      repeat (20) @(negedge clk);
      chk("stall_valid_held", 64'(out_valid), 64'(1));
      chk("stall_no_count", 64'(rounds_done), 64'(r0));
      @(posedge clk); #1 out_ready = 1;
      wait_idle("stall", 100);
      chk("stall_count", 64'(rounds_done), 64'(r0 + 1));

      // Reset while waiting on the decoder with a second frame pending.
      plan_q.push_back(mk_plan(0, 0, 1, 8'd0, 32'd0));
      src_q.push_back('{id: 16'h00A1, meas: 18'h00A1A});
      src_q.push_back('{id: 16'h00B2, meas: 18'h00B2B});
      repeat (8) @(negedge clk);
      chk("midwait_busy", 64'(busy), 64'(1));
      chk("midwait_pending", 64'(in_ready), 64'(0));
      do_reset("midwait");
      plan_q.push_back(mk_plan(0, 2, 0, 8'd7, 32'd70));
      src_q.push_back('{id: 16'h00C3, meas: 18'h00C3C});
      wait_idle("postreset", 200);
      chk("postreset_rounds", 64'(rounds_done), 64'(1));
      chk("postreset_timeouts", 64'(timeouts), 64'(0));

      // Random rounds with random gaps and a random sink.
      rand_sink = 1;
      for (int i = 0; i < 40; i++) begin
         src_q.push_back('{id: RW'($urandom), meas: PU'($urandom)});
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_idle("rand", 4000);
      rand_sink = 0;
      @(posedge clk); #1 out_ready = 1;
      chk("rand_rounds", 64'(rounds_done), 64'(model_rounds));
      chk("rand_timeouts", 64'(timeouts), 64'(model_to));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
